// File: rtl/fifo_pciecfg_sync.sv
// fifo_pciecfg_sync: single-clock first-word-fall-through FIFO for the PCIe
// configuration path. Provides occupancy count, programmable almost-full and
// almost-empty flags, and defined overflow/underflow behaviour.
// Optional error accounting (sticky overflow/underflow plus a saturating drop
// counter) is enabled by defining the macro FIFO_PCIECFG_ERR_EN; without it
// those outputs are tied low and err_clr has no effect.
module fifo_pciecfg_sync #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 7,
    parameter int AFULL_THRESH  = (1 << ADDRESS_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   count,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow,
    output logic [15:0]              drop_cnt
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_C   = DEPTH[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] AFULL_C   = AFULL_THRESH[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] AEMPTY_C  = AEMPTY_THRESH[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] ONE_C     = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDRESS_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [ADDRESS_WIDTH:0]   count_q, count_d;
    logic                     empty_q, empty_d;
    logic                     full_q, full_d;
    logic                     aFull_q, aFull_d;
    logic                     aEmpty_q, aEmpty_d;
    logic                     writeAccept;
    logic                     readAccept;

    // Accepted requests are qualified only by the registered flags.
    assign writeAccept = wr_en & ~full_q;
    assign readAccept  = rd_en & ~empty_q;

    // Next pointers, occupancy and the flags derived from the next occupancy.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (writeAccept) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (readAccept) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({writeAccept, readAccept})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        empty_d  = (count_d == '0);
        full_d   = (count_d == DEPTH_C);
        aFull_d  = (count_d >= AFULL_C);
        aEmpty_d = (count_d <= AEMPTY_C);
    end

    // Pointer, count and flag registers; reset empties the FIFO and ignores requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aFull_q  <= 1'b0;
            aEmpty_q <= 1'b1;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aFull_q  <= aFull_d;
            aEmpty_q <= aEmpty_d;
        end
    end

    // Storage is written on accepted writes only and is never reset.
    always_ff @(posedge clk) begin
        if (!rst && writeAccept) begin
            mem[wrPtr_q] <= din;
        end
    end

    assign dout         = mem[rdPtr_q];
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = aFull_q;
    assign almost_empty = aEmpty_q;
    assign count        = count_q;

`ifdef FIFO_PCIECFG_ERR_EN
    logic        overflow_q;
    logic        underflow_q;
    logic [15:0] dropCnt_q;

    // Sticky error flags and saturating drop counter; a clear beats a new event.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dropCnt_q   <= '0;
        end else begin
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
                if (dropCnt_q != 16'hFFFF) begin
                    dropCnt_q <= dropCnt_q + 16'd1;
                end
            end
            if (rd_en && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign drop_cnt  = dropCnt_q;
`else
    logic unusedErrClr;
    assign unusedErrClr = err_clr;
    assign overflow     = 1'b0;
    assign underflow    = 1'b0;
    assign drop_cnt     = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_pciecfg_sync.sv
// Directed testbench for fifo_pciecfg_sync with DEPTH=8, AFULL_THRESH=6,
// AEMPTY_THRESH=1. Error-accounting expectations follow FIFO_PCIECFG_ERR_EN.
module tb_fifo_pciecfg_sync;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  din;
    logic        rd_en;
    logic [7:0]  dout;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
    logic        err_clr;
    logic        overflow;
    logic        underflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

`ifdef FIFO_PCIECFG_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    fifo_pciecfg_sync #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (3),
        .AFULL_THRESH  (6),
        .AEMPTY_THRESH (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of requests, then return the inputs to idle 1 time unit after the edge.
    task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rd,
                                 input logic clr, input logic rs);
        wr_en   = wr;
        din     = d;
        rd_en   = rd;
        err_clr = clr;
        rst     = rs;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        rst     = 1'b0;
    endtask

    // Single comparison: counted, and reported with tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Occupancy and all four status flags in one call.
    task automatic checkFlags(input string tag, input int cnt, input logic emp, input logic ful,
                              input logic ae, input logic af);
        checkOutput({tag, ".count"}, 16'(cnt), 16'(count));
        checkOutput({tag, ".empty"}, 16'(empty), 16'(emp));
        checkOutput({tag, ".full"}, 16'(full), 16'(ful));
        checkOutput({tag, ".almost_empty"}, 16'(almost_empty), 16'(ae));
        checkOutput({tag, ".almost_full"}, 16'(almost_full), 16'(af));
    endtask

    // Error accounting outputs; expectations collapse to zero without the macro.
    task automatic checkErrors(input string tag, input logic ov, input logic un, input int drops);
        checkOutput({tag, ".overflow"}, 16'(overflow), 16'(ov & ERR_EN));
        checkOutput({tag, ".underflow"}, 16'(underflow), 16'(un & ERR_EN));
        checkOutput({tag, ".drop_cnt"}, drop_cnt, ERR_EN ? 16'(drops) : 16'd0);
    endtask

    initial begin
        wr_en = 1'b0; rd_en = 1'b0; din = 8'h00; err_clr = 1'b0; rst = 1'b0;
        $display("[TB] start");

        // Reset state.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkFlags("reset", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkErrors("reset", 1'b0, 1'b0, 0);

        // Write-then-read.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        checkFlags("wr1", 1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("wr1.dout", 16'(dout), 16'h11);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        checkFlags("wr2", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wr2.dout", 16'(dout), 16'h11);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        checkOutput("wr3.count", 16'(count), 16'd3);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("rd1.count", 16'(count), 16'd2);
        checkOutput("rd1.dout", 16'(dout), 16'h22);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("rd2.count", 16'(count), 16'd1);
        checkOutput("rd2.dout", 16'(dout), 16'h33);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkFlags("rd3", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkErrors("rd3", 1'b0, 1'b0, 0);

        // Fill with thresholds observed on the way up (pointers start at 3).
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
            checkFlags($sformatf("fill%0d", i), i + 1, 1'b0, (i == 7), (i + 1) <= 1, (i + 1) >= 6);
        end
        checkOutput("fill.dout", 16'(dout), 16'h40);

        // Ninth write is dropped.
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        checkFlags("wr9", 8, 1'b0, 1'b1, 1'b0, 1'b1);
        checkErrors("wr9", 1'b1, 1'b0, 1);

        // Simultaneous read and write when full: read wins, write dropped.
        applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 1'b0);
        checkFlags("simFull", 7, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("simFull.dout", 16'(dout), 16'h41);
        checkErrors("simFull", 1'b1, 1'b0, 2);

        // Drain seven: order preserved, almost_full clears at 5, 0xDD never appears.
        for (int i = 1; i < 8; i++) begin
            checkOutput($sformatf("drain%0d.dout", i), 16'(dout), 16'h40 + 16'(i));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkFlags($sformatf("drain%0d", i), 7 - i, (i == 7), 1'b0, (7 - i) <= 1, (7 - i) >= 6);
        end

        // Eight more across the pointer wrap, then read them back in order.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
        end
        checkFlags("wrap.full", 8, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("wrap%0d.dout", i), 16'(dout), 16'h80 + 16'(i));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checkFlags("wrap.empty", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Simultaneous read and write when empty: write wins, read is underflow.
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        checkFlags("simEmpty", 1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("simEmpty.dout", 16'(dout), 16'h5A);
        checkErrors("simEmpty", 1'b1, 1'b1, 2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("simEmpty.pop", 16'(empty), 16'd1);

        // Reset mid-operation with five entries stored; a write in the reset cycle is ignored.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("pre.count", 16'(count), 16'd5);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        checkFlags("midReset", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkErrors("midReset", 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        checkOutput("postReset.dout", 16'(dout), 16'hAA);
        checkOutput("postReset.count", 16'(count), 16'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Error accounting: three writes while full.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("ovf.count", 16'(count), 16'd8);
        checkErrors("ovf", 1'b1, 1'b0, 3);

        // Clear has priority over a simultaneous dropped write.
        applyStimulus(1'b1, 8'hF1, 1'b0, 1'b1, 1'b0);
        checkErrors("clrPrio", 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 8'hF2, 1'b0, 1'b0, 1'b0);
        checkErrors("ovfAgain", 1'b1, 1'b0, 1);

        // Drain and read once while empty.
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("errDrain%0d.dout", i), 16'(dout), 16'h10 + 16'(i));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkFlags("udf", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkErrors("udf", 1'b1, 1'b1, 1);

        // Explicit clear returns all error state to zero.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkErrors("errClr", 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the bench always ends.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout: observed running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
